nnrv_id_pipe: RTL and testbench

NNRV_ID_PIPE -- requirements
Module: nnrv_id_pipe

---
 rtl/nnrv_pkg.sv | 96 +++++++++
 rtl/nnrv_id_pipe_if.sv | 41 ++++
 rtl/nnrv_imm_gen.sv | 36 +++
 rtl/nnrv_id_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_nnrv_id_pipe.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nnrv_pkg.sv
// Shared decode constants for the nnrv instruction-decode stage.
// Holds opcode, funct3 and funct7 codes, the exec-type and class encodings,
// the packed control payload, and the funct3 legality helpers.
package nnrv_pkg;

    localparam int unsigned ETYPE_W = 5;
    localparam int unsigned REG_W   = 5;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [ETYPE_W-1:0] TYPE_NONE = 5'd0;
    localparam logic [ETYPE_W-1:0] TYPE_ADD  = 5'd1;
    localparam logic [ETYPE_W-1:0] TYPE_SUB  = 5'd2;
    localparam logic [ETYPE_W-1:0] TYPE_SLT  = 5'd3;
    localparam logic [ETYPE_W-1:0] TYPE_SLTU = 5'd4;
    localparam logic [ETYPE_W-1:0] TYPE_XOR  = 5'd5;
    localparam logic [ETYPE_W-1:0] TYPE_OR   = 5'd6;
    localparam logic [ETYPE_W-1:0] TYPE_AND  = 5'd7;
    localparam logic [ETYPE_W-1:0] TYPE_SLL  = 5'd8;
    localparam logic [ETYPE_W-1:0] TYPE_SRL  = 5'd9;
    localparam logic [ETYPE_W-1:0] TYPE_SRA  = 5'd10;
    // MUL..REMU occupy TYPE_MUL + funct3 (11..18)
    localparam logic [ETYPE_W-1:0] TYPE_MUL  = 5'd11;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_BR   = 3'd1,
        CLS_JAL  = 3'd2,
        CLS_JALR = 3'd3,
        CLS_LD   = 3'd4,
        CLS_ST   = 3'd5,
        CLS_SYS  = 3'd6
    } cls_e;

    typedef struct packed {
        logic [ETYPE_W-1:0] etype;
        cls_e               cls;
        logic [2:0]         funct3;
        logic [REG_W-1:0]   rd;
        logic               rd_we;
        logic               illegal;
    } dec_ctrl_t;

    // Base ALU op from funct3; alt selects SUB/SRA.
    function automatic logic [ETYPE_W-1:0] alu_type(input logic [2:0] f3, input logic alt);
        logic [ETYPE_W-1:0] t;
        case (f3)
            F3_ADD:  t = alt ? TYPE_SUB : TYPE_ADD;
            F3_SLL:  t = TYPE_SLL;
            F3_SLT:  t = TYPE_SLT;
            F3_SLTU: t = TYPE_SLTU;
            F3_XOR:  t = TYPE_XOR;
            F3_SR:   t = alt ? TYPE_SRA : TYPE_SRL;
            F3_OR:   t = TYPE_OR;
            default: t = TYPE_AND;
        endcase
        return t;
    endfunction

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    endfunction

    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/nnrv_id_pipe_if.sv
// Fetch -> decode -> execute bundle for the nnrv decode stage.
// master: the decode stage's view; slave: the surrounding fetch/regfile/execute view.
interface nnrv_id_pipe_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned TYPE_W      = 5
);
    logic                   if_valid;
    logic                   if_ready;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic [XLEN-1:0]        if_pc;
    logic                   flush;
    logic [4:0]             reg_r1;
    logic [4:0]             reg_r2;
    logic [XLEN-1:0]        reg_r1_reg;
    logic [XLEN-1:0]        reg_r2_reg;
    logic                   exec_valid;
    logic                   exec_ready;
    logic [XLEN-1:0]        exec_op1;
    logic [XLEN-1:0]        exec_op2;
    logic [XLEN-1:0]        exec_imm;
    logic [XLEN-1:0]        exec_pc;
    logic [TYPE_W-1:0]      exec_type;
    logic [2:0]             exec_cls;
    logic [2:0]             exec_funct3;
    logic [4:0]             exec_rd;
    logic                   exec_rd_we;
    logic                   exec_illegal;

    modport master (
        input  if_valid, if_instr, if_pc, flush, reg_r1_reg, reg_r2_reg, exec_ready,
        output if_ready, reg_r1, reg_r2, exec_valid, exec_op1, exec_op2, exec_imm,
               exec_pc, exec_type, exec_cls, exec_funct3, exec_rd, exec_rd_we, exec_illegal
    );

    modport slave (
        output if_valid, if_instr, if_pc, flush, reg_r1_reg, reg_r2_reg, exec_ready,
        input  if_ready, reg_r1, reg_r2, exec_valid, exec_op1, exec_op2, exec_imm,
               exec_pc, exec_type, exec_cls, exec_funct3, exec_rd, exec_rd_we, exec_illegal
    );
endinterface

// File: rtl/nnrv_imm_gen.sv
// Combinational RISC-V immediate generator: I/S/B/U/J forms, sign-extended
// from instr[31] to XLEN.
// Ports: i_instr (instruction word) -> o_imm_i/s/b/u/j.
module nnrv_imm_gen #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic [XLEN-1:0]        o_imm_i,
    output logic [XLEN-1:0]        o_imm_s,
    output logic [XLEN-1:0]        o_imm_b,
    output logic [XLEN-1:0]        o_imm_u,
    output logic [XLEN-1:0]        o_imm_j
);
    logic signed [11:0] imm_i_raw;
    logic signed [11:0] imm_s_raw;
    logic signed [12:0] imm_b_raw;
    logic signed [31:0] imm_u_raw;
    logic signed [20:0] imm_j_raw;
    logic               unused_opcode;

    assign imm_i_raw = i_instr[31:20];
    assign imm_s_raw = {i_instr[31:25], i_instr[11:7]};
    assign imm_b_raw = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_u_raw = {i_instr[31:12], 12'b0};
    assign imm_j_raw = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Size casts of signed values sign-extend
    assign o_imm_i = XLEN'(imm_i_raw);
    assign o_imm_s = XLEN'(imm_s_raw);
    assign o_imm_b = XLEN'(imm_b_raw);
    assign o_imm_u = XLEN'(imm_u_raw);
    assign o_imm_j = XLEN'(imm_j_raw);

    assign unused_opcode = ^i_instr[6:0];
endmodule

// File: rtl/nnrv_id_pipe.sv
// nnrv instruction-decode pipeline stage: accepts an instruction from fetch,
// reads rs1/rs2 combinationally, and registers operands, immediate, PC and
// control for execute behind a valid/ready handshake (1-cycle latency).
// Ports: i_clk/i_rst_n; fetch i_if_*/o_if_ready; flush i_flush;
// regfile o_reg_r1/r2, i_reg_r1/r2_reg; execute o_exec_*/i_exec_ready.
// Optional: define NNRV_M_EXT_EN to decode the M extension (funct7=0x01).
module nnrv_id_pipe
    import nnrv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned TYPE_W      = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_if_valid,
    output logic                   o_if_ready,
    input  logic [INSTR_WIDTH-1:0] i_if_instr,
    input  logic [XLEN-1:0]        i_if_pc,
    input  logic                   i_flush,
    output logic [4:0]             o_reg_r1,
    output logic [4:0]             o_reg_r2,
    input  logic [XLEN-1:0]        i_reg_r1_reg,
    input  logic [XLEN-1:0]        i_reg_r2_reg,
    output logic                   o_exec_valid,
    input  logic                   i_exec_ready,
    output logic [XLEN-1:0]        o_exec_op1,
    output logic [XLEN-1:0]        o_exec_op2,
    output logic [XLEN-1:0]        o_exec_imm,
    output logic [XLEN-1:0]        o_exec_pc,
    output logic [TYPE_W-1:0]      o_exec_type,
    output logic [2:0]             o_exec_cls,
    output logic [2:0]             o_exec_funct3,
    output logic [4:0]             o_exec_rd,
    output logic                   o_exec_rd_we,
    output logic                   o_exec_illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d, pc_q, pc_d;
    dec_ctrl_t       ctrl_q, ctrl_d;

    logic            transfer_c;
    logic            rd_we_ok;
    logic [XLEN-1:0] op1_dec, op2_dec, imm_dec;
    dec_ctrl_t       ctrl_dec;

    assign opcode   = i_if_instr[6:0];
    assign funct3   = i_if_instr[14:12];
    assign funct7   = i_if_instr[31:25];
    assign o_reg_r1 = i_if_instr[19:15];
    assign o_reg_r2 = i_if_instr[24:20];

    nnrv_imm_gen #(.XLEN(XLEN), .INSTR_WIDTH(INSTR_WIDTH)) u_imm_gen (
        .i_instr (i_if_instr),
        .o_imm_i (imm_i),
        .o_imm_s (imm_s),
        .o_imm_b (imm_b),
        .o_imm_u (imm_u),
        .o_imm_j (imm_j)
    );

    // Decode the incoming instruction into operands, immediate and control
    always_comb begin
        op1_dec         = '0;
        op2_dec         = '0;
        imm_dec         = '0;
        ctrl_dec        = '0;
        ctrl_dec.funct3 = funct3;
        ctrl_dec.rd     = i_if_instr[11:7];
        ctrl_dec.etype  = TYPE_ADD;
        ctrl_dec.cls    = CLS_ALU;
        rd_we_ok        = 1'b1;
        case (opcode)
            OPC_OP: begin
                op1_dec = i_reg_r1_reg;
                op2_dec = i_reg_r2_reg;
                if (funct7 == F7_MULDIV) begin
`ifdef NNRV_M_EXT_EN
                    ctrl_dec.etype = TYPE_MUL + ETYPE_W'(funct3);
`else
                    ctrl_dec.etype   = alu_type(funct3, 1'b0);
                    ctrl_dec.illegal = 1'b1;
`endif
                end else begin
                    ctrl_dec.etype   = alu_type(funct3, (funct7 == F7_ALT) &&
                                                ((funct3 == F3_ADD) || (funct3 == F3_SR)));
                    ctrl_dec.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
            end
            OPC_OP_IMM: begin
                op1_dec        = i_reg_r1_reg;
                op2_dec        = imm_i;
                imm_dec        = imm_i;
                ctrl_dec.etype = alu_type(funct3, (funct3 == F3_SR) && i_if_instr[30]);
                // Shift amounts share the funct7 field; only 0x00/0x20 are encodings
                if ((funct3 == F3_SLL) || (funct3 == F3_SR)) begin
                    ctrl_dec.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
            end
            OPC_LOAD: begin
                op1_dec          = i_reg_r1_reg;
                op2_dec          = imm_i;
                imm_dec          = imm_i;
                ctrl_dec.cls     = CLS_LD;
                ctrl_dec.illegal = !load_f3_ok(funct3);
            end
            OPC_STORE: begin
                op1_dec          = i_reg_r1_reg;
                op2_dec          = i_reg_r2_reg;
                imm_dec          = imm_s;
                ctrl_dec.cls     = CLS_ST;
                ctrl_dec.illegal = !store_f3_ok(funct3);
                rd_we_ok         = 1'b0;
            end
            OPC_BRANCH: begin
                op1_dec          = i_reg_r1_reg;
                op2_dec          = i_reg_r2_reg;
                imm_dec          = imm_b;
                ctrl_dec.etype   = TYPE_NONE;
                ctrl_dec.cls     = CLS_BR;
                ctrl_dec.illegal = !branch_f3_ok(funct3);
                rd_we_ok         = 1'b0;
            end
            OPC_JAL: begin
                op1_dec      = i_if_pc;
                op2_dec      = XLEN'(4);
                imm_dec      = imm_j;
                ctrl_dec.cls = CLS_JAL;
            end
            OPC_JALR: begin
                op1_dec          = i_reg_r1_reg;
                op2_dec          = imm_i;
                imm_dec          = imm_i;
                ctrl_dec.cls     = CLS_JALR;
                ctrl_dec.illegal = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                op2_dec = imm_u;
                imm_dec = imm_u;
            end
            OPC_AUIPC: begin
                op1_dec = i_if_pc;
                op2_dec = imm_u;
                imm_dec = imm_u;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                op1_dec        = i_reg_r1_reg;
                imm_dec        = imm_i;
                ctrl_dec.etype = TYPE_NONE;
                ctrl_dec.cls   = CLS_SYS;
                rd_we_ok       = 1'b0;
            end
            default: begin
                ctrl_dec.etype   = TYPE_NONE;
                ctrl_dec.cls     = CLS_SYS;
                ctrl_dec.illegal = 1'b1;
            end
        endcase
        ctrl_dec.rd_we = rd_we_ok && (ctrl_dec.rd != 5'd0) && !ctrl_dec.illegal;
    end

    assign o_if_ready = !valid_q || i_exec_ready;
    assign transfer_c = i_if_valid && o_if_ready;

    // Handshake: flush wins, then capture on transfer, then drain on ready
    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (transfer_c) begin
            valid_d = 1'b1;
            op1_d   = op1_dec;
            op2_d   = op2_dec;
            imm_d   = imm_dec;
            pc_d    = i_if_pc;
            ctrl_d  = ctrl_dec;
        end else if (i_exec_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign o_exec_valid   = valid_q;
    assign o_exec_op1     = op1_q;
    assign o_exec_op2     = op2_q;
    assign o_exec_imm     = imm_q;
    assign o_exec_pc      = pc_q;
    assign o_exec_type    = TYPE_W'(ctrl_q.etype);
    assign o_exec_cls     = ctrl_q.cls;
    assign o_exec_funct3  = ctrl_q.funct3;
    assign o_exec_rd      = ctrl_q.rd;
    assign o_exec_rd_we   = ctrl_q.rd_we;
    assign o_exec_illegal = ctrl_q.illegal;
endmodule

// File: tb/tb_nnrv_id_pipe.sv
// Directed self-checking bench for nnrv_id_pipe.
module tb_nnrv_id_pipe;
    import nnrv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    nnrv_id_pipe_if #(.XLEN(32), .INSTR_WIDTH(32), .TYPE_W(5)) bus ();

    nnrv_id_pipe #(.XLEN(32), .INSTR_WIDTH(32), .TYPE_W(5)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_if_valid     (bus.if_valid),
        .o_if_ready     (bus.if_ready),
        .i_if_instr     (bus.if_instr),
        .i_if_pc        (bus.if_pc),
        .i_flush        (bus.flush),
        .o_reg_r1       (bus.reg_r1),
        .o_reg_r2       (bus.reg_r2),
        .i_reg_r1_reg   (bus.reg_r1_reg),
        .i_reg_r2_reg   (bus.reg_r2_reg),
        .o_exec_valid   (bus.exec_valid),
        .i_exec_ready   (bus.exec_ready),
        .o_exec_op1     (bus.exec_op1),
        .o_exec_op2     (bus.exec_op2),
        .o_exec_imm     (bus.exec_imm),
        .o_exec_pc      (bus.exec_pc),
        .o_exec_type    (bus.exec_type),
        .o_exec_cls     (bus.exec_cls),
        .o_exec_funct3  (bus.exec_funct3),
        .o_exec_rd      (bus.exec_rd),
        .o_exec_rd_we   (bus.exec_rd_we),
        .o_exec_illegal (bus.exec_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one instruction for a single cycle (accepted if ready)
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1d, input logic [31:0] r2d);
        bus.if_valid   = 1'b1;
        bus.if_instr   = instr;
        bus.if_pc      = pc;
        bus.reg_r1_reg = r1d;
        bus.reg_r2_reg = r2d;
        tick();
        bus.if_valid = 1'b0;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        bus.if_valid   = 1'b0;
        bus.if_instr   = '0;
        bus.if_pc      = '0;
        bus.flush      = 1'b0;
        bus.reg_r1_reg = '0;
        bus.reg_r2_reg = '0;
        bus.exec_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_valid", bus.exec_valid, 0);
        check("rst_if_ready", bus.if_ready, 1);
        check("rst_op1", bus.exec_op1, 0);
        check("rst_type", bus.exec_type, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI x1,x2,-1
        bus.if_instr = 32'hFFF10093;
        #1;
        check("addi_rs1_idx", bus.reg_r1, 2);
        send(32'hFFF10093, 32'h0, 32'd5, 32'd0);
        check("addi_valid", bus.exec_valid, 1);
        check("addi_op1", bus.exec_op1, 32'd5);
        check("addi_op2", bus.exec_op2, 32'hFFFFFFFF);
        check("addi_imm", bus.exec_imm, 32'hFFFFFFFF);
        check("addi_type", bus.exec_type, 1);
        check("addi_rd", bus.exec_rd, 1);
        check("addi_rd_we", bus.exec_rd_we, 1);
        check("addi_cls", bus.exec_cls, CLS_ALU);

        // SUB x3,x1,x2 then back-pressure for 3 cycles
        send(32'h402081B3, 32'h4, 32'd10, 32'd3);
        check("sub_type", bus.exec_type, 2);
        check("sub_op1", bus.exec_op1, 32'd10);
        check("sub_op2", bus.exec_op2, 32'd3);
        check("sub_rd", bus.exec_rd, 3);
        bus.exec_ready = 1'b0;
        bus.if_valid   = 1'b1;
        bus.if_instr   = 32'hFFF10093;
        bus.reg_r1_reg = 32'd99;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_if_ready", bus.if_ready, 0);
            tick();
            check("hold_valid", bus.exec_valid, 1);
            check("hold_type", bus.exec_type, 2);
            check("hold_op1", bus.exec_op1, 32'd10);
            check("hold_rd", bus.exec_rd, 3);
        end
        bus.if_valid   = 1'b0;
        bus.exec_ready = 1'b1;
        tick();
        check("drain_valid", bus.exec_valid, 0);

        // LUI x4 then AUIPC x5 at pc=0x100
        send(32'h12345237, 32'h0, 32'd7, 32'd7);
        check("lui_op1", bus.exec_op1, 0);
        check("lui_op2", bus.exec_op2, 32'h12345000);
        check("lui_rd", bus.exec_rd, 4);
        check("lui_type", bus.exec_type, 1);
        send(32'h12345297, 32'h100, 32'd7, 32'd7);
        check("auipc_op1", bus.exec_op1, 32'h100);
        check("auipc_op2", bus.exec_op2, 32'h12345000);
        check("auipc_pc", bus.exec_pc, 32'h100);

        // JAL x1,+8 at pc=0x200
        send(32'h008000EF, 32'h200, 32'd0, 32'd0);
        check("jal_op1", bus.exec_op1, 32'h200);
        check("jal_op2", bus.exec_op2, 32'd4);
        check("jal_imm", bus.exec_imm, 32'd8);
        check("jal_cls", bus.exec_cls, CLS_JAL);
        check("jal_rd_we", bus.exec_rd_we, 1);

        // BEQ x1,x2,-4
        send(32'hFE208EE3, 32'h300, 32'd11, 32'd22);
        check("beq_imm", bus.exec_imm, 32'hFFFFFFFC);
        check("beq_op2", bus.exec_op2, 32'd22);
        check("beq_type", bus.exec_type, 0);
        check("beq_cls", bus.exec_cls, CLS_BR);
        check("beq_rd_we", bus.exec_rd_we, 0);
        check("beq_illegal", bus.exec_illegal, 0);

        // SW x2,8(x1)
        send(32'h0020A423, 32'h304, 32'd1, 32'h55);
        check("sw_imm", bus.exec_imm, 32'd8);
        check("sw_op2", bus.exec_op2, 32'h55);
        check("sw_cls", bus.exec_cls, CLS_ST);
        check("sw_type", bus.exec_type, 1);
        check("sw_rd_we", bus.exec_rd_we, 0);
        check("sw_funct3", bus.exec_funct3, 3'b010);

        // LOAD with funct3=011 is not an RV32 load
        send(32'h0000B083, 32'h308, 32'd0, 32'd0);
        check("ld_bad_illegal", bus.exec_illegal, 1);
        check("ld_bad_cls", bus.exec_cls, CLS_LD);
        check("ld_bad_rd_we", bus.exec_rd_we, 0);

        // Unknown opcode
        send(32'h0000007F, 32'h30C, 32'd0, 32'd0);
        check("unk_illegal", bus.exec_illegal, 1);
        check("unk_rd_we", bus.exec_rd_we, 0);

        // MUL x5,x6,x7
        send(32'h027302B3, 32'h310, 32'd6, 32'd7);
`ifdef NNRV_M_EXT_EN
        check("mul_type", bus.exec_type, 11);
        check("mul_illegal", bus.exec_illegal, 0);
        check("mul_rd_we", bus.exec_rd_we, 1);
`else
        check("mul_illegal", bus.exec_illegal, 1);
        check("mul_type", bus.exec_type, 1);
        check("mul_rd_we", bus.exec_rd_we, 0);
`endif
        check("mul_op2", bus.exec_op2, 32'd7);

        // ADDI x0,x0,1: rd=0 suppresses write enable
        send(32'h00100013, 32'h314, 32'd0, 32'd0);
        check("x0_rd_we", bus.exec_rd_we, 0);
        check("x0_illegal", bus.exec_illegal, 0);
        tick();
        check("idle_valid", bus.exec_valid, 0);

        // Flush together with an incoming instruction
        bus.flush = 1'b1;
        send(32'hFFF10093, 32'h400, 32'd5, 32'd0);
        bus.flush = 1'b0;
        check("flush_in_valid", bus.exec_valid, 0);

        // Flush of a held instruction
        send(32'hFFF10093, 32'h404, 32'd5, 32'd0);
        bus.exec_ready = 1'b0;
        tick();
        check("flush_hold_pre", bus.exec_valid, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_hold_valid", bus.exec_valid, 0);
        bus.exec_ready = 1'b1;

        // Reset asserted mid-handshake
        send(32'h402081B3, 32'h500, 32'd10, 32'd3);
        bus.exec_ready = 1'b0;
        bus.if_valid   = 1'b1;
        tick();
        check("rst_mid_pre", bus.exec_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", bus.exec_valid, 0);
        check("rst_mid_op1", bus.exec_op1, 0);
        check("rst_mid_type", bus.exec_type, 0);
        check("rst_mid_rd", bus.exec_rd, 0);
        check("rst_mid_if_ready", bus.if_ready, 1);
        tick();
        bus.if_valid   = 1'b0;
        bus.exec_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", bus.exec_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule
